// File: rtl/stream_pooling_2x2_pkg.sv
// Shared definitions for the streaming 2x2 pooling stage: pooling mode encoding and width helper.
package stream_pooling_2x2_pkg;

    typedef enum logic {
        MODE_AVG = 1'b0,
        MODE_MAX = 1'b1
    } pool_mode_e;

    // Counter/index width that stays at least one bit for tiny dimensions.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_pooling_2x2_pool_combine.sv
// Combinational 2-input combiner: full-width sum (average path) or zero-extended max.
module pool_combine
    import stream_pooling_2x2_pkg::*;
#(
    parameter int unsigned in_width = 8
) (
    input  logic [in_width-1:0] a,
    input  logic [in_width-1:0] b,
    input  logic                mode,
    output logic [in_width:0]   y
);

    localparam int unsigned OW = in_width + 1;

    always_comb begin
        y = OW'(a) + OW'(b);
        if (mode == MODE_MAX) begin
            y = (a > b) ? OW'(a) : OW'(b);
        end
    end

endmodule

// File: rtl/stream_pooling_2x2.sv
// Streaming 2x2 / stride-2 pooling (average or max) over raster pixels with a half-width line buffer.
module stream_pooling_2x2
    import stream_pooling_2x2_pkg::*;
#(
    parameter int unsigned resolution = 8,
    parameter int unsigned IMG_WIDTH  = 28,
    parameter int unsigned IMG_HEIGHT = 28
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mode,
    input  logic [resolution-1:0] in_pixel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [resolution-1:0] out_pixel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int unsigned PW  = resolution + 1;
    localparam int unsigned SW  = resolution + 2;
    localparam int unsigned CW  = clog2_min1(IMG_WIDTH);
    localparam int unsigned RW  = clog2_min1(IMG_HEIGHT);
    localparam int unsigned LBN = IMG_WIDTH / 2;
    localparam int unsigned LBW = clog2_min1(LBN);

    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    pool_mode_e            mode_q, mode_d;
    logic [resolution-1:0] hold_q, hold_d;
    logic [resolution-1:0] out_pixel_q, out_pixel_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [PW-1:0]         line_buf_q [LBN];

    logic                  in_beat, out_beat;
    logic                  col_end, row_end;
    logic [LBW-1:0]        lb_idx;
    logic [PW-1:0]         pair, lb_rd;
    logic [SW-1:0]         vsum;
    logic [resolution-1:0] pooled;

    assign in_ready  = !out_valid_q || out_ready;
    assign in_beat   = in_valid && in_ready;
    assign out_beat  = out_valid_q && out_ready;
    assign out_valid = out_valid_q;
    assign out_pixel = out_pixel_q;
    assign out_last  = out_last_q;

    assign col_end = (col_q == CW'(IMG_WIDTH - 1));
    assign row_end = (row_q == RW'(IMG_HEIGHT - 1));
    assign lb_idx  = LBW'(col_q >> 1);
    assign lb_rd   = line_buf_q[lb_idx];

    pool_combine #(.in_width(resolution)) u_horiz (
        .a    (hold_q),
        .b    (in_pixel),
        .mode (mode_q),
        .y    (pair)
    );

    pool_combine #(.in_width(PW)) u_vert (
        .a    (lb_rd),
        .b    (pair),
        .mode (mode_q),
        .y    (vsum)
    );

    // Average keeps the floor of sum/4; max result always fits in resolution bits.
    assign pooled = (mode_q == MODE_MAX) ? vsum[resolution-1:0] : vsum[SW-1:2];

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        mode_d      = mode_q;
        hold_d      = hold_q;
        out_pixel_d = out_pixel_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (out_beat) begin
            out_valid_d = 1'b0;
        end

        if (in_beat) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end

            // The (0,0) beat never combines, so the new mode is in place for the first pair.
            if (col_q == '0 && row_q == '0) begin
                mode_d = pool_mode_e'(mode);
            end

            if (!col_q[0]) begin
                hold_d = in_pixel;
            end

            if (row_q[0] && col_q[0]) begin
                out_pixel_d = pooled;
                out_valid_d = 1'b1;
                out_last_d  = row_end && col_end;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            col_q       <= '0;
            row_q       <= '0;
            mode_q      <= MODE_AVG;
            hold_q      <= '0;
            out_pixel_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            mode_q      <= mode_d;
            hold_q      <= hold_d;
            out_pixel_q <= out_pixel_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Line buffer holds the even-row pair sums; contents need no reset.
    always_ff @(posedge clk) begin
        if (in_beat && !row_q[0] && col_q[0]) begin
            line_buf_q[lb_idx] <= pair;
        end
    end

endmodule

// File: tb/tb_stream_pooling_2x2.sv
// Self-checking bench for stream_pooling_2x2 on a 4x4 frame: vector table, corner sequences, random frames.
module tb_stream_pooling_2x2;

    localparam int unsigned RES = 8;
    localparam int unsigned W   = 4;
    localparam int unsigned H   = 4;
    localparam int unsigned NP  = W * H;
    localparam int unsigned NO  = (W / 2) * (H / 2);

    logic           clk;
    logic           reset_n;
    logic           mode;
    logic [RES-1:0] in_pixel;
    logic           in_valid;
    logic           in_ready;
    logic [RES-1:0] out_pixel;
    logic           out_valid;
    logic           out_ready;
    logic           out_last;

    typedef logic [RES-1:0] frame_t [NP];

    typedef struct {
        string          name;
        logic           m;
        logic [RES-1:0] pix [NP];
        logic [RES-1:0] exp [NO];
    } vec_t;

    typedef struct {
        logic [RES-1:0] pixel;
        logic           last;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[5];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   rand_en = 0;

    stream_pooling_2x2 #(
        .resolution (RES),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mode      (mode),
        .in_pixel  (in_pixel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_pixel (out_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard: every output beat is matched against the next expected pooled pixel.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_pixel", int'(out_pixel), int'(e.pixel));
                check("out_last", int'(out_last), int'(e.last));
            end
        end
    end

    // Reference: pool each 2x2 block directly from the frame array.
    task automatic model_push(input frame_t f, input logic m);
        exp_t e;
        int   a, b, c, d, s, mx;
        for (int r = 0; r < int'(H / 2); r++) begin
            for (int k = 0; k < int'(W / 2); k++) begin
                a  = int'(f[(2*r)*W + 2*k]);
                b  = int'(f[(2*r)*W + 2*k + 1]);
                c  = int'(f[(2*r+1)*W + 2*k]);
                d  = int'(f[(2*r+1)*W + 2*k + 1]);
                s  = (a + b + c + d) / 4;
                mx = a;
                if (b > mx) mx = b;
                if (c > mx) mx = c;
                if (d > mx) mx = d;
                e.pixel = RES'(m ? mx : s);
                e.last  = (r == int'(H / 2) - 1) && (k == int'(W / 2) - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic push_table(input logic [RES-1:0] ex [NO]);
        exp_t e;
        for (int k = 0; k < int'(NO); k++) begin
            e.pixel = ex[k];
            e.last  = (k == int'(NO) - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_pixel(input logic [RES-1:0] p, input logic m);
        bit acc;
        int cnt;
        if (rand_en && $urandom_range(0, 3) == 0) begin
            in_valid  = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_pixel = p;
        mode     = m;
        acc      = 1'b0;
        cnt      = 0;
        while (!acc && cnt < 100) begin
            if (rand_en) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            cnt++;
        end
        in_valid = 1'b0;
        if (!acc) check("in_ready_timeout", 0, 1);
    endtask

    task automatic send_frame(input frame_t f, input logic m, input bit lat_chk);
        bit corner;
        for (int i = 0; i < int'(NP); i++) begin
            send_pixel(f[i], m);
            if (lat_chk) begin
                corner = ((i / W) % 2 == 1) && ((i % W) % 2 == 1);
                check("out_valid_latency", int'(out_valid), int'(corner));
                if (corner) check("out_last_at_beat", int'(out_last), int'(i == int'(NP) - 1));
            end
        end
    endtask

    task automatic drain();
        int cnt = 0;
        while (exp_q.size() != 0 && cnt < 200) begin
            out_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            cnt++;
        end
        out_ready = 1'b1;
        check("queue_drained", exp_q.size(), 0);
        check("idle_after_drain", int'(out_valid), 0);
    endtask

    initial begin
        frame_t ramp, rf;
        logic [RES-1:0] ex_avg [NO];
        logic [RES-1:0] ex_max [NO];
        logic           rm;

        ex_avg = '{8'd2, 8'd4, 8'd10, 8'd12};
        ex_max = '{8'd5, 8'd7, 8'd13, 8'd15};
        for (int i = 0; i < int'(NP); i++) ramp[i] = RES'(i);

        vecs[0].name = "ramp_avg"; vecs[0].m = 1'b0; vecs[0].exp = ex_avg;
        vecs[1].name = "ramp_max"; vecs[1].m = 1'b1; vecs[1].exp = ex_max;
        vecs[2].name = "sat_avg";  vecs[2].m = 1'b0; vecs[2].exp = '{8'd255, 8'd255, 8'd255, 8'd255};
        vecs[3].name = "sat_max";  vecs[3].m = 1'b1; vecs[3].exp = '{8'd255, 8'd255, 8'd255, 8'd255};
        vecs[4].name = "checker_avg"; vecs[4].m = 1'b0; vecs[4].exp = '{8'd127, 8'd127, 8'd127, 8'd127};
        for (int i = 0; i < int'(NP); i++) begin
            vecs[0].pix[i] = ramp[i];
            vecs[1].pix[i] = ramp[i];
            vecs[2].pix[i] = 8'd255;
            vecs[3].pix[i] = 8'd255;
            vecs[4].pix[i] = (((i / W) + (i % W)) % 2 == 1) ? 8'd255 : 8'd0;
        end

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_pixel  = '0;
        mode      = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_pixel", int'(out_pixel), 0);
        check("rst_out_last", int'(out_last), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", int'(in_ready), 1);

        for (int v = 0; v < 5; v++) begin
            push_table(vecs[v].exp);
            send_frame(vecs[v].pix, vecs[v].m, 1'b1);
            drain();
        end

        // Backpressure: hold the first output for 5 cycles with pixel 6 waiting.
        push_table(ex_avg);
        for (int i = 0; i < 6; i++) send_pixel(ramp[i], 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pixel  = ramp[6];
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_pixel", int'(out_pixel), 2);
            check("bp_in_ready", int'(in_ready), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int i = 6; i < int'(NP); i++) send_pixel(ramp[i], 1'b0);
        drain();

        // Mode change mid-frame is ignored until the next frame starts.
        push_table(ex_avg);
        for (int i = 0; i < int'(NP); i++) send_pixel(ramp[i], (i < 2) ? 1'b0 : 1'b1);
        drain();
        push_table(ex_max);
        send_frame(ramp, 1'b1, 1'b0);
        drain();

        // Reset after pixel 6 discards the partial frame.
        push_table('{8'd2, 8'd0, 8'd0, 8'd0});
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        for (int i = 0; i < 7; i++) send_pixel(ramp[i], 1'b0);
        check("pre_rst_queue_empty", exp_q.size(), 0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_last", int'(out_last), 0);
        reset_n = 1'b1;
        push_table(ex_avg);
        send_frame(ramp, 1'b0, 1'b1);
        drain();

        // Random frames with random gaps and backpressure against the reference.
        rand_en = 1'b1;
        for (int f = 0; f < 8; f++) begin
            rm = 1'($urandom_range(0, 1));
            for (int i = 0; i < int'(NP); i++) begin
                case ($urandom_range(0, 5))
                    0:       rf[i] = 8'd255;
                    1:       rf[i] = 8'd0;
                    default: rf[i] = RES'($urandom_range(0, 255));
                endcase
            end
            model_push(rf, rm);
            send_frame(rf, rm, 1'b0);
        end
        drain();
        rand_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
